// File: rtl/gpreg_transfer_seq_if.sv
// Handshake and strobe bundle between the control unit and the
// general-purpose register transfer sequencer.
interface gpreg_transfer_seq_if #(
   parameter int REG_ADDR_W = 2
);
   localparam int NUM_REGS = 2**REG_ADDR_W;

   logic                  REQ;
   logic [REG_ADDR_W-1:0] SRC;
   logic [1:0]            BUS_SEL;
   logic [REG_ADDR_W-1:0] DST;
   logic                  DST_EN;
   logic                  BUSY;
   logic                  DONE;
   logic                  ERROR;
   logic [NUM_REGS-1:0]   LOAD;
   logic [NUM_REGS-1:0]   ASSERT_MAIN_bar;
   logic [NUM_REGS-1:0]   ASSERT_LHS_bar;
   logic [NUM_REGS-1:0]   ASSERT_RHS_bar;

   // Control unit side: issues requests, watches status and strobes.
   modport master (
      output REQ, SRC, BUS_SEL, DST, DST_EN,
      input  BUSY, DONE, ERROR, LOAD,
      input  ASSERT_MAIN_bar, ASSERT_LHS_bar, ASSERT_RHS_bar
   );

   // Sequencer side: accepts requests, drives the register strobes.
   modport slave (
      input  REQ, SRC, BUS_SEL, DST, DST_EN,
      output BUSY, DONE, ERROR, LOAD,
      output ASSERT_MAIN_bar, ASSERT_LHS_bar, ASSERT_RHS_bar
   );
endinterface

// File: rtl/gpreg_transfer_seq.sv
// Register-file transfer sequencer: bus drive/settle, latch pulse, hold, done.
// Optional GPREG_SEQ_XFER_COUNT_EN adds a wrapping 16-bit XFER_COUNT output.
module gpreg_transfer_seq #(
   parameter int REG_ADDR_W    = 2,
   parameter int SETTLE_CYCLES = 1,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic                    CLK,
   input  logic                    RESET,
   gpreg_transfer_seq_if.slave     bus
`ifdef GPREG_SEQ_XFER_COUNT_EN
   ,
   output logic [15:0]             XFER_COUNT
`endif
);
   localparam int NUM_REGS = 2**REG_ADDR_W;
   localparam int CNT_MAX  = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
   localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {IDLE, DRIVE, LATCH, HOLD, FINISH} state_t;

   state_t                state_q, state_n;
   logic [CNT_W-1:0]      cnt_q, cnt_n;
   logic [REG_ADDR_W-1:0] src_q, src_n, dst_q, dst_n;
   logic [1:0]            sel_q, sel_n;
   logic                  en_q, en_n;
   logic                  error_n, busy_n, done_n;
   logic [NUM_REGS-1:0]   load_n, main_n, lhs_n, rhs_n;

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_n;
   end

   // Request capture and timing counter only matter outside IDLE.
   always_ff @(posedge CLK) begin
      cnt_q <= cnt_n;
      src_q <= src_n;
      sel_q <= sel_n;
      dst_q <= dst_n;
      en_q  <= en_n;
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      src_n   = src_q;
      sel_n   = sel_q;
      dst_n   = dst_q;
      en_n    = en_q;
      error_n = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.REQ) begin
               // Loads are only fed from MAIN, so DST_EN needs BUS_SEL=0.
               if (bus.BUS_SEL == 2'd3 || (bus.DST_EN && bus.BUS_SEL != 2'd0)) begin
                  error_n = 1'b1;
               end else begin
                  state_n = DRIVE;
                  cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
                  src_n   = bus.SRC;
                  sel_n   = bus.BUS_SEL;
                  dst_n   = bus.DST;
                  en_n    = bus.DST_EN;
               end
            end
         end
         DRIVE: begin
            if (cnt_q == '0) state_n = LATCH;
            else             cnt_n   = cnt_q - 1'b1;
         end
         LATCH: begin
            state_n = HOLD;
            cnt_n   = CNT_W'(HOLD_CYCLES - 1);
         end
         HOLD: begin
            if (cnt_q == '0) state_n = FINISH;
            else             cnt_n   = cnt_q - 1'b1;
         end
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so that they are registered
   // yet line up with the state they describe.
   always_comb begin
      busy_n = (state_n != IDLE);
      done_n = (state_n == FINISH);
      load_n = '0;
      main_n = '1;
      lhs_n  = '1;
      rhs_n  = '1;
      if (state_n == DRIVE || state_n == LATCH || state_n == HOLD) begin
         case (sel_n)
            2'd0:    main_n[src_n] = 1'b0;
            2'd1:    lhs_n[src_n]  = 1'b0;
            2'd2:    rhs_n[src_n]  = 1'b0;
            default: ;
         endcase
      end
      if (state_n == LATCH && en_n) load_n[dst_n] = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         bus.BUSY            <= 1'b0;
         bus.DONE            <= 1'b0;
         bus.ERROR           <= 1'b0;
         bus.LOAD            <= '0;
         bus.ASSERT_MAIN_bar <= '1;
         bus.ASSERT_LHS_bar  <= '1;
         bus.ASSERT_RHS_bar  <= '1;
      end else begin
         bus.BUSY            <= busy_n;
         bus.DONE            <= done_n;
         bus.ERROR           <= error_n;
         bus.LOAD            <= load_n;
         bus.ASSERT_MAIN_bar <= main_n;
         bus.ASSERT_LHS_bar  <= lhs_n;
         bus.ASSERT_RHS_bar  <= rhs_n;
      end
   end

`ifdef GPREG_SEQ_XFER_COUNT_EN
   always_ff @(posedge CLK) begin
      if (RESET)       XFER_COUNT <= 16'h0000;
      else if (done_n) XFER_COUNT <= XFER_COUNT + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_gpreg_transfer_seq.sv
// Randomized self-checking bench for gpreg_transfer_seq against a
// per-cycle timeline model of each transfer.
module tb_gpreg_transfer_seq;
   localparam int REG_ADDR_W = 2;
   localparam int NUM_REGS   = 2**REG_ADDR_W;
   localparam int SETTLE     = 1;
   localparam int HOLD       = 1;
   localparam int XFER_LEN   = SETTLE + HOLD + 2;

   logic CLK = 1'b0;
   logic RESET;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   count_m  = 0;

   gpreg_transfer_seq_if #(.REG_ADDR_W(REG_ADDR_W)) bus ();

`ifdef GPREG_SEQ_XFER_COUNT_EN
   logic [15:0] xfer_count;
`endif

   gpreg_transfer_seq #(
      .REG_ADDR_W   (REG_ADDR_W),
      .SETTLE_CYCLES(SETTLE),
      .HOLD_CYCLES  (HOLD)
   ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus)
`ifdef GPREG_SEQ_XFER_COUNT_EN
      ,
      .XFER_COUNT(xfer_count)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pack(input logic busy, input logic done, input logic error,
                                        input logic [NUM_REGS-1:0] load, input logic [NUM_REGS-1:0] m,
                                        input logic [NUM_REGS-1:0] l, input logic [NUM_REGS-1:0] r);
      return 64'({busy, done, error, load, m, l, r});
   endfunction

   function automatic logic [63:0] observe();
      return pack(bus.BUSY, bus.DONE, bus.ERROR, bus.LOAD,
                  bus.ASSERT_MAIN_bar, bus.ASSERT_LHS_bar, bus.ASSERT_RHS_bar);
   endfunction

   function automatic logic [63:0] idle_vec(input logic error);
      return pack(1'b0, 1'b0, error, '0, '1, '1, '1);
   endfunction

   // Cycle j (1 = first cycle after the accepting edge) of an accepted transfer.
   function automatic logic [63:0] xfer_exp(input int j, input int src, input int sel,
                                            input int dst, input bit en);
      logic [NUM_REGS-1:0] drv, m, l, r, ld;
      drv = '1;
      ld  = '0;
      if (j >= 1 && j <= SETTLE + 1 + HOLD) drv[src] = 1'b0;
      m = (sel == 0) ? drv : '1;
      l = (sel == 1) ? drv : '1;
      r = (sel == 2) ? drv : '1;
      if (j == SETTLE + 1 && en) ld[dst] = 1'b1;
      return pack(j >= 1 && j <= XFER_LEN, j == XFER_LEN, 1'b0, ld, m, l, r);
   endfunction

   task automatic check_count(input string tag);
`ifdef GPREG_SEQ_XFER_COUNT_EN
      check_val({tag, "_cnt"}, 64'(xfer_count), 64'(count_m[15:0]));
`endif
   endtask

   task automatic drive_noise();
      bus.SRC     = REG_ADDR_W'($urandom);
      bus.BUS_SEL = 2'($urandom);
      bus.DST     = REG_ADDR_W'($urandom);
      bus.DST_EN  = 1'($urandom);
   endtask

   // Called just after a negedge with the DUT going to be IDLE at the next edge.
   task automatic run_req(input int src, input int sel, input int dst, input bit en,
                          input int abort_j, input string tag);
      bit rej;
      rej = (sel == 3) || (en && sel != 0);
      bus.REQ     = 1'b1;
      bus.SRC     = REG_ADDR_W'(src);
      bus.BUS_SEL = 2'(sel);
      bus.DST     = REG_ADDR_W'(dst);
      bus.DST_EN  = en;
      @(posedge CLK);
      #1;
      bus.REQ = 1'b0;
      drive_noise();
      if (rej) begin
         @(negedge CLK);
         check_val({tag, "_err"}, observe(), idle_vec(1'b1));
         check_count(tag);
         @(negedge CLK);
         check_val({tag, "_after_err"}, observe(), idle_vec(1'b0));
         return;
      end
      for (int j = 1; j <= XFER_LEN; j++) begin
         @(negedge CLK);
         if (j == XFER_LEN) count_m++;
         check_val($sformatf("%s_c%0d", tag, j), observe(), xfer_exp(j, src, sel, dst, en));
         check_count(tag);
         if (j == abort_j) begin
            RESET       = 1'b1;
            bus.REQ     = 1'b1;
            bus.SRC     = '0;
            bus.BUS_SEL = 2'd0;
            bus.DST     = REG_ADDR_W'(1);
            bus.DST_EN  = 1'b1;
            @(negedge CLK);
            count_m = 0;
            check_val({tag, "_abort"}, observe(), idle_vec(1'b0));
            check_count({tag, "_abort"});
            RESET   = 1'b0;
            bus.REQ = 1'b0;
            return;
         end
         bus.REQ = (j < XFER_LEN) ? 1'($urandom) : 1'b0;
         drive_noise();
      end
      @(negedge CLK);
      check_val({tag, "_idle"}, observe(), idle_vec(1'b0));
   endtask

   initial begin
      int sel, abort_j;
      RESET   = 1'b1;
      bus.REQ = 1'b1;
      drive_noise();
      repeat (3) @(negedge CLK);
      check_val("reset", observe(), idle_vec(1'b0));
      check_count("reset");
      RESET   = 1'b0;
      bus.REQ = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive_noise();
         @(negedge CLK);
         check_val("idle", observe(), idle_vec(1'b0));
      end

      run_req(1, 0, 2, 1, 0, "main_load");
      run_req(3, 2, 0, 0, 0, "rhs");
      run_req(0, 1, 0, 0, 0, "lhs");
      run_req(0, 1, 2, 1, 0, "rej_lhs_load");
      run_req(1, 3, 0, 0, 0, "rej_sel3");
      run_req(0, 0, 1, 1, SETTLE + 1, "abort_latch");
      run_req(2, 0, 3, 1, 0, "after_abort");
      run_req(2, 0, 2, 1, 0, "self_load");

      for (int t = 0; t < 80; t++) begin
         sel     = int'($urandom_range(3, 0));
         abort_j = ($urandom_range(7, 0) == 0) ? int'($urandom_range(XFER_LEN, 1)) : 0;
         run_req(int'($urandom_range(NUM_REGS - 1, 0)), sel,
                 int'($urandom_range(NUM_REGS - 1, 0)), 1'($urandom), abort_j, "rand");
         repeat ($urandom_range(2, 0)) begin
            @(negedge CLK);
            check_val("rand_gap", observe(), idle_vec(1'b0));
         end
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule
